// File: rtl/risk_pkg.sv
// Shared level encoding and default thresholds for the risk alert path.
// Thresholds are on the fuzzy estimator's 0..255 output scale.
package risk_pkg;

    typedef enum logic [1:0] {
        LVL_SAFE  = 2'd0,
        LVL_WATCH = 2'd1,
        LVL_ALERT = 2'd2
    } level_e;

    localparam int         DEF_WIN_LOG2  = 2;
    localparam logic [7:0] DEF_WARN_ON   = 8'd128;
    localparam logic [7:0] DEF_WARN_OFF  = 8'd96;
    localparam logic [7:0] DEF_ALERT_ON  = 8'd200;
    localparam logic [7:0] DEF_ALERT_OFF = 8'd160;
    localparam int         DEF_PERSIST   = 3;

endpackage

// File: rtl/risk_window_avg.sv
// Power-of-two moving average over the last N accepted risk samples.
// eval pulses the cycle after each accept once the window has filled.
module risk_window_avg #(
    parameter int WIN_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic [7:0] risk,
    output logic [7:0] avg_risk,
    output logic       eval
);

    localparam int N  = 1 << WIN_LOG2;
    localparam int SW = 8 + WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(N);
    localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2 + 1)'(N - 1);

    logic [7:0]        win [N];
    logic [SW-1:0]     sum;
    logic [SW-1:0]     sum_next;
    logic [WIN_LOG2:0] fill;

    // Slots start at zero, so the sum stays exact even during warm-up.
    assign sum_next = sum + SW'(risk) - SW'(win[N-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) win[i] <= '0;
            sum      <= '0;
            fill     <= '0;
            avg_risk <= '0;
            eval     <= 1'b0;
        end else begin
            eval <= accept && (fill >= FILL_LAST);
            if (accept) begin
                win[0] <= risk;
                for (int i = 1; i < N; i++) win[i] <= win[i-1];
                sum      <= sum_next;
                avg_risk <= 8'(sum_next >> WIN_LOG2);
                if (fill != FILL_FULL) fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/risk_alert_ctrl.sv
// Smoothed risk classifier (SAFE/WATCH/ALERT) with hysteresis, persistence,
// a latched operator alarm and a saturating count of ALERT entries.
module risk_alert_ctrl
    import risk_pkg::*;
#(
    parameter int         WIN_LOG2  = DEF_WIN_LOG2,
    parameter logic [7:0] WARN_ON   = DEF_WARN_ON,
    parameter logic [7:0] WARN_OFF  = DEF_WARN_OFF,
    parameter logic [7:0] ALERT_ON  = DEF_ALERT_ON,
    parameter logic [7:0] ALERT_OFF = DEF_ALERT_OFF,
    parameter int         PERSIST   = DEF_PERSIST
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       risk_valid,
    input  logic [7:0] risk,
    input  logic       ack,
    output logic [7:0] avg_risk,
    output logic [1:0] level,
    output logic       alarm,
    output logic [7:0] alert_count
);

    localparam logic [3:0] PERSIST_LAST = 4'(PERSIST - 1);

    level_e     state;
    logic       eval;
    logic       up_cond;
    logic       dn_cond;
    logic       up_hit;
    logic       dn_hit;
    logic       enter_alert;
    logic [3:0] up_cnt;
    logic [3:0] dn_cnt;

    risk_window_avg #(.WIN_LOG2(WIN_LOG2)) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (en && risk_valid),
        .risk     (risk),
        .avg_risk (avg_risk),
        .eval     (eval)
    );

    always_comb begin
        up_cond = 1'b0;
        dn_cond = 1'b0;
        case (state)
            LVL_SAFE:  up_cond = avg_risk >= WARN_ON;
            LVL_WATCH: begin
                up_cond = avg_risk >= ALERT_ON;
                dn_cond = avg_risk < WARN_OFF;
            end
            LVL_ALERT: dn_cond = avg_risk < ALERT_OFF;
            default:   ;
        endcase
    end

    assign up_hit      = eval && up_cond && (up_cnt == PERSIST_LAST);
    assign dn_hit      = eval && dn_cond && (dn_cnt == PERSIST_LAST);
    assign enter_alert = up_hit && (state == LVL_WATCH);
    assign level       = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LVL_SAFE;
            up_cnt      <= '0;
            dn_cnt      <= '0;
            alarm       <= 1'b0;
            alert_count <= '0;
        end else begin
            if (up_hit) begin
                state  <= (state == LVL_SAFE) ? LVL_WATCH : LVL_ALERT;
                up_cnt <= '0;
                dn_cnt <= '0;
            end else if (dn_hit) begin
                state  <= (state == LVL_ALERT) ? LVL_WATCH : LVL_SAFE;
                up_cnt <= '0;
                dn_cnt <= '0;
            end else if (eval) begin
                up_cnt <= up_cond ? up_cnt + 1'b1 : '0;
                dn_cnt <= dn_cond ? dn_cnt + 1'b1 : '0;
            end

            // A new ALERT entry outranks a simultaneous acknowledge.
            if (enter_alert) begin
                alarm <= 1'b1;
                if (alert_count != 8'hFF) alert_count <= alert_count + 1'b1;
            end else if (ack && state != LVL_ALERT) begin
                alarm <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (WARN_OFF < WARN_ON && WARN_ON <= ALERT_OFF && ALERT_OFF < ALERT_ON
                    && PERSIST >= 1 && PERSIST <= 15)
                else $error("risk_alert_ctrl: illegal threshold/persistence configuration");
        end
    end

endmodule

// File: tb/tb_risk_alert_ctrl.sv
// Directed table-driven bench for risk_alert_ctrl with hand-computed expectations.
module tb_risk_alert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       risk_valid;
    logic [7:0] risk;
    logic       ack;
    logic [7:0] avg_risk;
    logic [1:0] level;
    logic       alarm;
    logic [7:0] alert_count;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       vld;
        logic [7:0] risk;
        logic       ack;
        logic [7:0] avg;
        logic [1:0] lvl;
        logic       alarm;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    risk_alert_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .risk_valid  (risk_valid),
        .risk        (risk),
        .ack         (ack),
        .avg_risk    (avg_risk),
        .level       (level),
        .alarm       (alarm),
        .alert_count (alert_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic v, input int rk, input logic a,
                       input int avg, input int lvl, input logic al, input int cnt);
        vec_t t;
        t.rst_n = r; t.en = e; t.vld = v; t.risk = 8'(rk); t.ack = a;
        t.avg = 8'(avg); t.lvl = 2'(lvl); t.alarm = al; t.cnt = 8'(cnt);
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive_step(input logic r, input logic e, input logic v, input int rk, input logic a);
        rst_n = r; en = e; risk_valid = v; risk = 8'(rk); ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input int avg, input int lvl,
                           input int al, input int cnt);
        chk({tag, ".avg_risk"}, idx, int'(avg_risk), avg);
        chk({tag, ".level"}, idx, int'(level), lvl);
        chk({tag, ".alarm"}, idx, int'(alarm), al);
        chk({tag, ".alert_count"}, idx, int'(alert_count), cnt);
    endtask

    initial begin
        // rows: rst en vld risk ack | avg lvl alarm cnt  (outputs seen just after that row's edge)
        for (int i = 0; i < 6; i++) add(1, 1, 1, 150, 0, (i == 0) ? 37 : (i == 1) ? 75 : (i == 2) ? 112 : 150, 0, 0, 0);
        add(1, 1, 1, 220, 0, 167, 1, 0, 0);
        add(1, 1, 1, 220, 0, 185, 1, 0, 0);
        add(1, 1, 1, 220, 0, 202, 1, 0, 0);
        add(1, 1, 1, 220, 0, 220, 1, 0, 0);
        add(1, 1, 1, 220, 0, 220, 1, 0, 0);
        add(1, 1, 1,   0, 0, 165, 2, 1, 1);
        add(1, 1, 1,   0, 1, 110, 2, 1, 1);
        add(1, 1, 1,   0, 0,  55, 2, 1, 1);
        add(1, 1, 1,   0, 0,   0, 2, 1, 1);
        add(1, 1, 1,   0, 0,   0, 1, 1, 1);
        add(1, 1, 1,   0, 0,   0, 1, 1, 1);
        add(1, 1, 1,   0, 0,   0, 1, 1, 1);
        add(1, 1, 1,   0, 0,   0, 0, 1, 1);
        add(1, 1, 0,   0, 1,   0, 0, 0, 1);
        add(1, 1, 1, 255, 0,  63, 0, 0, 1);
        add(1, 1, 1, 255, 0, 127, 0, 0, 1);
        add(1, 1, 1, 255, 0, 191, 0, 0, 1);
        add(1, 1, 1, 255, 0, 255, 0, 0, 1);
        add(1, 1, 1, 255, 0, 255, 0, 0, 1);
        add(1, 1, 1, 255, 0, 255, 1, 0, 1);
        add(1, 1, 1, 255, 0, 255, 1, 0, 1);
        add(1, 1, 1, 255, 0, 255, 1, 0, 1);
        add(1, 1, 0,   0, 1, 255, 2, 1, 2);
        add(1, 1, 0,   0, 0, 255, 2, 1, 2);
        add(0, 1, 1, 200, 0,   0, 0, 0, 0);
        add(0, 1, 1, 200, 0,   0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 1, 1, 150, 0, (i == 0) ? 37 : (i == 1) ? 75 : (i == 2) ? 112 : 150, 0, 0, 0);
        add(1, 1, 1, 210, 0, 165, 1, 0, 0);
        add(1, 1, 1, 210, 0, 180, 1, 0, 0);
        add(1, 1, 1, 210, 0, 195, 1, 0, 0);
        add(1, 1, 1, 210, 0, 210, 1, 0, 0);
        add(1, 1, 1, 250, 0, 220, 1, 0, 0);
        add(1, 1, 1, 120, 0, 197, 1, 0, 0);
        add(1, 1, 1, 250, 0, 207, 1, 0, 0);
        add(1, 1, 1, 250, 0, 217, 1, 0, 0);
        add(1, 1, 1, 120, 0, 185, 1, 0, 0);
        add(1, 0, 1,   0, 0, 185, 1, 0, 0);
        add(1, 0, 1,   0, 0, 185, 1, 0, 0);
        add(1, 0, 1, 255, 0, 185, 1, 0, 0);
        add(1, 1, 0,   0, 0, 185, 1, 0, 0);

        rst_n = 1'b0; en = 1'b0; risk_valid = 1'b0; risk = '0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive_step(tbl[i].rst_n, tbl[i].en, tbl[i].vld, int'(tbl[i].risk), tbl[i].ack);
            chk_all("table", i + 1, int'(tbl[i].avg), int'(tbl[i].lvl), int'(tbl[i].alarm), int'(tbl[i].cnt));
        end

        // Mid-stream reset must drop the fill count: the first three samples
        // after it may not be evaluated, so WATCH arrives only after sample 6.
        drive_step(0, 1, 1, 99, 0);
        drive_step(0, 1, 1, 99, 0);
        chk_all("midreset", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive_step(1, 1, 1, 255, 0);
            chk("warmup.avg_risk", i, int'(avg_risk), (i == 1) ? 63 : (i == 2) ? 127 : (i == 3) ? 191 : 255);
            chk("warmup.level", i, int'(level), 0);
        end
        drive_step(1, 1, 0, 0, 0);
        chk("warmup.level", 7, int'(level), 1);
        chk("warmup.alarm", 7, int'(alarm), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
